// File: rtl/encoder_period_meter.sv
// encoder_period_meter
// ---------------------------------------------------------------------------
// Measures the quadrature-encoder phase-A period in iClk100M cycles and issues
// one division request per period to the downstream Divider, which computes
// speed = SPEED_K / period. The operands are held stable while a request is
// outstanding. The next request is issued only after the Divider reports
// completion.
//
// Optional feature (compile-time macro):
//   ENC_GLITCH_FILTER_EN - adds a FILT_LEN-sample agreement filter on both
//                          synchronised phases. Pulses shorter than FILT_LEN
//                          cycles are dropped, and edge latency grows by
//                          FILT_LEN cycles.
//
// Parameters:
//   SPEED_K      dividend presented on oA with every request
//   TIMEOUT_CYC  period count at which the wheel is declared stalled
//   FILT_LEN     filter length; exists only when ENC_GLITCH_FILTER_EN is defined
//
// Ports:
//   iClk100M  in   1   system clock, 100 MHz
//   iRstN     in   1   asynchronous active-low reset
//   iEncA     in   1   encoder phase A (asynchronous)
//   iEncB     in   1   encoder phase B (asynchronous)
//   iDivDone  in   1   Divider completion pulse
//   oA        out  32  dividend to Divider
//   oB        out  32  divisor to Divider (measured period, always >= 1)
//   oEn       out  1   one-cycle start pulse to Divider
//   oDir      out  1   phase B level at phase-A rise (1 = forward)
//   oStall    out  1   high while no phase-A rise for >= TIMEOUT_CYC cycles
// ---------------------------------------------------------------------------
module encoder_period_meter #(
  parameter logic [31:0] SPEED_K     = 32'd100_000_000,
  parameter logic [31:0] TIMEOUT_CYC = 32'd10_000_000
`ifdef ENC_GLITCH_FILTER_EN
  ,
  parameter int          FILT_LEN    = 4
`endif
) (
  input  logic        iClk100M,
  input  logic        iRstN,
  input  logic        iEncA,
  input  logic        iEncB,
  input  logic        iDivDone,
  output logic [31:0] oA,
  output logic [31:0] oB,
  output logic        oEn,
  output logic        oDir,
  output logic        oStall
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic        r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic        w_a_lvl, w_b_lvl;
  logic        r_a_d;
  logic        w_rise, w_cap, w_done;
  logic [31:0] r_cnt, w_cnt_nxt, w_period;
  logic        r_armed;
  logic        r_pend;
  logic [31:0] r_pend_b;
  state_t      r_state;

  // ---- stage: 2-FF synchronisers on both phases ----
  always_ff @(posedge iClk100M or negedge iRstN) begin
    if (!iRstN) begin
      r_a_s1 <= 1'b0;
      r_a_s2 <= 1'b0;
      r_b_s1 <= 1'b0;
      r_b_s2 <= 1'b0;
    end else begin
      r_a_s1 <= iEncA;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= iEncB;
      r_b_s2 <= r_b_s1;
    end
  end

`ifdef ENC_GLITCH_FILTER_EN
  // ---- stage: agreement filter ----
  // The window includes the current synchroniser output, so a level must hold
  // for FILT_LEN samples before the filtered phase follows it.
  logic [FILT_LEN-2:0] r_a_hist, r_b_hist;
  logic [FILT_LEN-1:0] w_a_win, w_b_win;
  logic                r_a_flt, r_b_flt;

  assign w_a_win = {r_a_hist, r_a_s2};
  assign w_b_win = {r_b_hist, r_b_s2};

  always_ff @(posedge iClk100M or negedge iRstN) begin
    if (!iRstN) begin
      r_a_hist <= '0;
      r_b_hist <= '0;
      r_a_flt  <= 1'b0;
      r_b_flt  <= 1'b0;
    end else begin
      r_a_hist <= w_a_win[FILT_LEN-2:0];
      r_b_hist <= w_b_win[FILT_LEN-2:0];
      if (&w_a_win)       r_a_flt <= 1'b1;
      else if (~|w_a_win) r_a_flt <= 1'b0;
      if (&w_b_win)       r_b_flt <= 1'b1;
      else if (~|w_b_win) r_b_flt <= 1'b0;
    end
  end

  assign w_a_lvl = r_a_flt;
  assign w_b_lvl = r_b_flt;
`else
  assign w_a_lvl = r_a_s2;
  assign w_b_lvl = r_b_s2;
`endif

  // ---- stage: edge detect and period counter ----
  always_ff @(posedge iClk100M or negedge iRstN) begin
    if (!iRstN) r_a_d <= 1'b0;
    else        r_a_d <= w_a_lvl;
  end

  assign w_rise   = w_a_lvl & ~r_a_d;
  assign w_cap    = w_rise & r_armed;
  // The counter restarts at 0 on each edge, so edges N cycles apart leave N-1
  // in the counter at the second edge.
  assign w_period = r_cnt + 32'd1;
  assign w_cnt_nxt = w_rise                    ? 32'd0 :
                     (r_cnt >= TIMEOUT_CYC)    ? TIMEOUT_CYC :
                                                 r_cnt + 32'd1;
  // A completion pulse in the same cycle as a start pulse cannot belong to
  // that request. Ignoring it keeps oEn from firing on consecutive cycles.
  assign w_done   = iDivDone & ~oEn;

  // ---- stage: request FSM and registered outputs ----
  always_ff @(posedge iClk100M or negedge iRstN) begin
    if (!iRstN) begin
      r_cnt    <= 32'd0;
      r_armed  <= 1'b0;
      r_pend   <= 1'b0;
      r_pend_b <= 32'd0;
      r_state  <= S_IDLE;
      oA       <= 32'd0;
      oB       <= 32'd0;
      oEn      <= 1'b0;
      oDir     <= 1'b0;
      oStall   <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      oEn   <= 1'b0;

      // The first edge after reset or a stall only restarts timing. It has no
      // valid start point, so it produces no period.
      if (w_rise) begin
        oDir <= w_b_lvl;
        if (!r_armed) r_armed <= 1'b1;
        else          oStall  <= 1'b0;
      end else if (w_cnt_nxt == TIMEOUT_CYC) begin
        oStall  <= 1'b1;
        r_armed <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_cap) begin
            oA      <= SPEED_K;
            oB      <= w_period;
            oEn     <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_done) begin
            // A period captured in the completion cycle is newer than any
            // pending one, so it wins.
            if (w_cap) begin
              oB     <= w_period;
              oEn    <= 1'b1;
              r_pend <= 1'b0;
            end else if (r_pend) begin
              oB     <= r_pend_b;
              oEn    <= 1'b1;
              r_pend <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_cap) begin
            r_pend_b <= w_period;
            r_pend   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_period_meter.sv
module tb_encoder_period_meter;

  localparam logic [31:0] K   = 32'd100_000_000;
  localparam logic [31:0] TMO = 32'd3000;
`ifdef ENC_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iEncA = 1'b0;
  logic        iEncB = 1'b0;
  logic        iDivDone = 1'b0;
  logic [31:0] oA, oB;
  logic        oEn, oDir, oStall;

  encoder_period_meter #(
    .SPEED_K    (K),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .iClk100M(clk),
    .iRstN   (iRstN),
    .iEncA   (iEncA),
    .iEncB   (iEncB),
    .iDivDone(iDivDone),
    .oA      (oA),
    .oB      (oB),
    .oEn     (oEn),
    .oDir    (oDir),
    .oStall  (oStall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    bit dir;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_en_cyc = -1;
  int   last_done_cyc = -1;
  int   en_cnt = 0;
  bit   en_after_done = 1'b0;
  bit   prev_en = 1'b0;
  int   div_lat = 40;
  int   div_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Output monitor, scoreboard consumer and Divider model.
  always @(posedge clk) begin
    bit   done_seen;
    exp_t e;
    cyc++;
    done_seen = iDivDone;
    #1;
    if (done_seen) last_done_cyc = cyc;
    if (oEn) begin
      en_cnt++;
      last_en_cyc   = cyc;
      en_after_done = (last_done_cyc == cyc);
      check("en_not_back_to_back", 32'(prev_en), 32'd0);
      check("oEn_has_expectation", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("oB_period", oB, 32'(e.per));
        check("oA_dividend", oA, K);
        check("oDir_at_issue", 32'(oDir), 32'(e.dir));
        check("oStall_at_issue", 32'(oStall), 32'd0);
      end
    end
    prev_en  = oEn;
    iDivDone = 1'b0;
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) iDivDone = 1'b1;
    end
    if (oEn) div_cnt = div_lat;
  end

  // One phase-A period: rise at the current negedge, high per/2, low the rest.
  task automatic a_cycle(input int per, input bit b, input int exp_per, input bit lat_chk);
    iEncB = b;
    iEncA = 1'b1;
    if (exp_per > 0) exp_q.push_back('{exp_per, b});
    if (lat_chk) begin
      for (int i = 1; i <= LAT; i++) begin
        @(posedge clk);
        #2;
        if (i == LAT) check("latency_en_high", 32'(oEn), 32'd1);
        else          check("latency_en_low", 32'(oEn), 32'd0);
      end
      @(negedge clk);
      repeat (per / 2 - LAT) @(negedge clk);
    end else begin
      repeat (per / 2) @(negedge clk);
    end
    iEncA = 1'b0;
    repeat (per - per / 2) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_oA", oA, 32'd0);
    check("rst_oB", oB, 32'd0);
    check("rst_oEn", 32'(oEn), 32'd0);
    check("rst_oDir", 32'(oDir), 32'd0);
    check("rst_oStall", 32'(oStall), 32'd1);
    @(negedge clk);
    iRstN = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_after_release", 32'(oStall), 32'd1);

    // Forward rotation, 1000-cycle period
    a_cycle(1000, 1'b1, -1, 1'b0);
    check("stall_after_unarmed_edge", 32'(oStall), 32'd1);
    check("no_oEn_on_first_edge", 32'(en_cnt), 32'd0);
    check("dir_after_first_edge", 32'(oDir), 32'd1);
    a_cycle(1000, 1'b1, 1000, 1'b1);
    a_cycle(1000, 1'b1, 1000, 1'b1);
    a_cycle(1000, 1'b1, 1000, 1'b1);
    check("stall_cleared", 32'(oStall), 32'd0);
    check("en_count_fwd", 32'(en_cnt), 32'd3);

    // Reverse rotation
    a_cycle(1000, 1'b0, 1000, 1'b1);
    a_cycle(1000, 1'b0, 1000, 1'b1);
    a_cycle(1000, 1'b0, 1000, 1'b1);
    check("dir_reverse", 32'(oDir), 32'd0);

    // Stall detection and rearm
    seen = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #2;
      if (oStall) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_seen", 32'(seen), 32'd1);
    check("stall_delay", 32'(cyc - last_en_cyc), TMO);
    @(negedge clk);
    e0 = en_cnt;
    a_cycle(500, 1'b1, -1, 1'b0);
    check("no_oEn_after_stall_edge", 32'(en_cnt - e0), 32'd0);
    check("stall_held_unarmed", 32'(oStall), 32'd1);
    check("dir_on_unarmed_edge", 32'(oDir), 32'd1);
    a_cycle(500, 1'b1, 500, 1'b1);
    check("stall_cleared_rearm", 32'(oStall), 32'd0);

    // Slow Divider: pending period, newest wins
    div_lat = 250;
    e0 = en_cnt;
    a_cycle(90, 1'b1, 500, 1'b1);
    a_cycle(100, 1'b1, -1, 1'b0);
    a_cycle(100, 1'b1, 100, 1'b0);
    repeat (400) @(negedge clk);
    check("pend_en_count", 32'(en_cnt - e0), 32'd2);
    check("pend_en_after_done", 32'(en_after_done), 32'd1);
    check("pend_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while waiting for the Divider
    iEncB = 1'b1;
    iEncA = 1'b1;
    exp_q.push_back('{500, 1'b1});
    repeat (20) @(negedge clk);
    check("wait_issued", 32'(en_cnt - e0), 32'd3);
    iRstN = 1'b0;
    iEncA = 1'b0;
    #1;
    check("midrst_oA", oA, 32'd0);
    check("midrst_oB", oB, 32'd0);
    check("midrst_oEn", 32'(oEn), 32'd0);
    check("midrst_oDir", 32'(oDir), 32'd0);
    check("midrst_oStall", 32'(oStall), 32'd1);
    repeat (5) @(negedge clk);
    iRstN = 1'b1;
    e0 = en_cnt;
    a_cycle(300, 1'b0, -1, 1'b0);
    check("no_oEn_after_reset_edge", 32'(en_cnt - e0), 32'd0);
    check("stall_after_reset_edge", 32'(oStall), 32'd1);
    a_cycle(300, 1'b0, 300, 1'b1);

    // Short glitch on phase A between real edges
    div_lat = 40;
    iEncB = 1'b1;
    iEncA = 1'b1;
    exp_q.push_back('{300, 1'b1});
    repeat (300) @(negedge clk);
    iEncA = 1'b0;
    repeat (100) @(negedge clk);
    iEncA = 1'b1;
`ifndef ENC_GLITCH_FILTER_EN
    exp_q.push_back('{400, 1'b1});
`endif
    repeat (2) @(negedge clk);
    iEncA = 1'b0;
    repeat (598) @(negedge clk);
`ifdef ENC_GLITCH_FILTER_EN
    a_cycle(1000, 1'b1, 1000, 1'b1);
`else
    a_cycle(1000, 1'b1, 600, 1'b1);
`endif
    a_cycle(1000, 1'b1, 1000, 1'b1);
    repeat (100) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
